// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// ID-stage hazard resolution for the five-stage pipeline. Tracks the GRF
// writers sitting in E, M and W together with the cycles each one still needs
// before its result can be forwarded. From that it raises the ID stall and
// picks a forwarding source for rs and rt. A countdown models the multi-cycle
// mult/div unit so that HI/LO consumers wait until it is idle.

module hazard_scoreboard #(
   parameter int TW          = 5,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ifReGrf1_Id,
   input  logic          ifReGrf2_Id,
   input  logic [4:0]    grfRa1_Id,
   input  logic [4:0]    grfRa2_Id,
   input  logic [TW-1:0] tUseRs_Id,
   input  logic [TW-1:0] tUseRt_Id,
   input  logic          ifWrGrf_Id,
   input  logic [4:0]    grfWa_Id,
   input  logic [TW-1:0] tNew_Id,
   input  logic          mdUse_Id,
   input  logic          mdStart_Id,
   input  logic          isDiv_Id,
   output logic          stall,
   output logic [1:0]    fwdSelRs,
   output logic [1:0]    fwdSelRt,
   output logic          fwdRdyRs,
   output logic          fwdRdyRt,
   output logic          mdBusy,
   output logic [31:0]   stallCount
);

   // One in-flight GRF writer. An entry with valid = 0 is a bubble.
   typedef struct packed {
      logic          valid;
      logic [4:0]    wa;
      logic [TW-1:0] tnew;
   } entry_t;

   // Result of looking an operand address up in the scoreboard.
   typedef struct packed {
      logic          hit;
      logic [1:0]    code;
      logic [TW-1:0] tnew;
   } match_t;

   localparam logic [1:0]    SEL_GRF   = 2'd0;
   localparam logic [1:0]    SEL_E     = 2'd1;
   localparam logic [1:0]    SEL_M     = 2'd2;
   localparam logic [1:0]    SEL_W     = 2'd3;
   localparam logic [4:0]    MULT_LOAD = 5'(MULT_CYCLES);
   localparam logic [4:0]    DIV_LOAD  = 5'(DIV_CYCLES);
   localparam logic [TW-1:0] TNEW_ONE  = TW'(1);
   localparam logic [31:0]   CNT_MAX   = 32'hFFFF_FFFF;

   // Decrement that sticks at zero: a result that is ready stays ready.
   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
      logic [TW-1:0] r;
      if (v == {TW{1'b0}}) begin
         r = {TW{1'b0}};
      end else begin
         r = v - TNEW_ONE;
      end
      return r;
   endfunction

   // Move an entry one stage down the pipe, one cycle closer to ready.
   function automatic entry_t age_entry(input entry_t e);
      entry_t r;
      r.valid = e.valid;
      r.wa    = e.wa;
      r.tnew  = sat_dec(e.tnew);
      return r;
   endfunction

   // Youngest writer of address a; $0 never matches since it is never written.
   function automatic match_t find_match(input logic [4:0] a,
                                         input entry_t     e,
                                         input entry_t     m,
                                         input entry_t     w);
      match_t r;
      r = '0;
      if (a == 5'd0) begin
         r = '0;
      end else if (e.valid && (e.wa == a)) begin
         r.hit  = 1'b1;
         r.code = SEL_E;
         r.tnew = e.tnew;
      end else if (m.valid && (m.wa == a)) begin
         r.hit  = 1'b1;
         r.code = SEL_M;
         r.tnew = m.tnew;
      end else if (w.valid && (w.wa == a)) begin
         r.hit  = 1'b1;
         r.code = SEL_W;
         r.tnew = w.tnew;
      end else begin
         r = '0;
      end
      return r;
   endfunction

   entry_t      e_q, m_q, w_q;
   entry_t      e_d, m_d, w_d;
   entry_t      id_entry;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   match_t      rs_match;
   match_t      rt_match;
   logic        rs_haz;
   logic        rt_haz;
   logic        md_haz;

   // Look both source operands up and derive forward selects and hazards.
   always_comb begin
      rs_match = find_match(grfRa1_Id, e_q, m_q, w_q);
      rt_match = find_match(grfRa2_Id, e_q, m_q, w_q);

      rs_haz = 1'b0;
      rt_haz = 1'b0;
      fwdSelRs = SEL_GRF;
      fwdSelRt = SEL_GRF;

      if (ifReGrf1_Id && rs_match.hit) begin
         fwdSelRs = rs_match.code;
         rs_haz   = (rs_match.tnew > tUseRs_Id);
      end else begin
         fwdSelRs = SEL_GRF;
         rs_haz   = 1'b0;
      end

      if (ifReGrf2_Id && rt_match.hit) begin
         fwdSelRt = rt_match.code;
         rt_haz   = (rt_match.tnew > tUseRt_Id);
      end else begin
         fwdSelRt = SEL_GRF;
         rt_haz   = 1'b0;
      end

      fwdRdyRs = (fwdSelRs != SEL_GRF) && (rs_match.tnew == {TW{1'b0}});
      fwdRdyRt = (fwdSelRt != SEL_GRF) && (rt_match.tnew == {TW{1'b0}});
   end

   // Combine operand hazards with the mult/div busy condition into the stall.
   always_comb begin
      mdBusy = (cnt_q != 5'd0);
      md_haz = mdUse_Id && mdBusy;
      stall  = rs_haz || rt_haz || md_haz;
   end

   // Next scoreboard contents: shift E->M->W, admit the ID writer unless stalled.
   always_comb begin
      id_entry = '0;
      if (ifWrGrf_Id && (grfWa_Id != 5'd0)) begin
         id_entry.valid = 1'b1;
         id_entry.wa    = grfWa_Id;
         id_entry.tnew  = tNew_Id;
      end else begin
         id_entry = '0;
      end

      if (stall) begin
         e_d = '0;
      end else begin
         e_d = id_entry;
      end

      m_d = age_entry(e_q);
      w_d = age_entry(m_q);
   end

   // Mult/div countdown: reload on an accepted issue, otherwise run down to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (mdStart_Id && !stall) begin
         if (isDiv_Id) begin
            cnt_d = DIV_LOAD;
         end else begin
            cnt_d = MULT_LOAD;
         end
      end else if (cnt_q != 5'd0) begin
         cnt_d = cnt_q - 5'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Stall cycle counter, saturating at all ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State registers; reset drops every in-flight writer and the busy count at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q         <= '0;
         m_q         <= '0;
         w_q         <= '0;
         cnt_q       <= 5'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         e_q         <= e_d;
         m_q         <= m_d;
         w_q         <= w_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed pipeline scenarios followed by random traffic. The reference model
// keeps each accepted writer with the cycle it entered E; its stage is its age
// and its remaining latency is tNew minus age, floored at zero. Mult/div busy
// is tracked as the last busy cycle number.

module tb_hazard_scoreboard;

   logic        clk;
   logic        reset;
   logic        ifReGrf1_Id, ifReGrf2_Id;
   logic [4:0]  grfRa1_Id, grfRa2_Id;
   logic [4:0]  tUseRs_Id, tUseRt_Id;
   logic        ifWrGrf_Id;
   logic [4:0]  grfWa_Id;
   logic [4:0]  tNew_Id;
   logic        mdUse_Id, mdStart_Id, isDiv_Id;
   logic        stall;
   logic [1:0]  fwdSelRs, fwdSelRt;
   logic        fwdRdyRs, fwdRdyRt;
   logic        mdBusy;
   logic [31:0] stallCount;

   hazard_scoreboard dut (
      .clk         (clk),
      .reset       (reset),
      .ifReGrf1_Id (ifReGrf1_Id),
      .ifReGrf2_Id (ifReGrf2_Id),
      .grfRa1_Id   (grfRa1_Id),
      .grfRa2_Id   (grfRa2_Id),
      .tUseRs_Id   (tUseRs_Id),
      .tUseRt_Id   (tUseRt_Id),
      .ifWrGrf_Id  (ifWrGrf_Id),
      .grfWa_Id    (grfWa_Id),
      .tNew_Id     (tNew_Id),
      .mdUse_Id    (mdUse_Id),
      .mdStart_Id  (mdStart_Id),
      .isDiv_Id    (isDiv_Id),
      .stall       (stall),
      .fwdSelRs    (fwdSelRs),
      .fwdSelRt    (fwdSelRt),
      .fwdRdyRs    (fwdRdyRs),
      .fwdRdyRt    (fwdRdyRt),
      .mdBusy      (mdBusy),
      .stallCount  (stallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int enter;
      int wa;
      int tnew;
   } wr_t;

   wr_t pipe_q[$];
   int  cyc       = 0;
   int  md_end    = -1;
   int  stall_cnt = 0;
   int  total     = 0;
   int  bad       = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pipe_q.delete();
      md_end    = -1;
      stall_cnt = 0;
   endtask

   // Youngest writer of ra still in E/M/W decides select, readiness and hazard.
   task automatic model_operand(input logic rd, input logic [4:0] ra, input logic [4:0] tuse,
                                output logic [1:0] sel, output logic rdy, output logic haz);
      int best_age = 3;
      int best_tn  = 0;
      int age;
      if (ra != 5'd0) begin
         foreach (pipe_q[i]) begin
            age = cyc - pipe_q[i].enter;
            if (pipe_q[i].wa == int'(ra) && age < best_age) begin
               best_age = age;
               best_tn  = (pipe_q[i].tnew > age) ? pipe_q[i].tnew - age : 0;
            end
         end
      end
      if (rd && best_age < 3) begin
         sel = 2'(best_age + 1);
         rdy = (best_tn == 0);
         haz = (best_tn > int'(tuse));
      end else begin
         sel = 2'd0;
         rdy = 1'b0;
         haz = 1'b0;
      end
   endtask

   task automatic model_all(output logic m_stall, output logic [1:0] s_rs, output logic [1:0] s_rt,
                            output logic r_rs, output logic r_rt, output logic busy);
      logic h_rs, h_rt;
      model_operand(ifReGrf1_Id, grfRa1_Id, tUseRs_Id, s_rs, r_rs, h_rs);
      model_operand(ifReGrf2_Id, grfRa2_Id, tUseRt_Id, s_rt, r_rt, h_rt);
      busy    = (cyc <= md_end);
      m_stall = h_rs || h_rt || (mdUse_Id && busy);
   endtask

   task automatic check_all();
      logic s, rr, rt, b;
      logic [1:0] sr, st;
      model_all(s, sr, st, rr, rt, b);
      chk("stall",      32'(stall),    32'(s));
      chk("fwdSelRs",   32'(fwdSelRs), 32'(sr));
      chk("fwdSelRt",   32'(fwdSelRt), 32'(st));
      chk("fwdRdyRs",   32'(fwdRdyRs), 32'(rr));
      chk("fwdRdyRt",   32'(fwdRdyRt), 32'(rt));
      chk("mdBusy",     32'(mdBusy),   32'(b));
      chk("stallCount", stallCount,    32'(stall_cnt));
   endtask

   // Advance one clock; the model retires/admits writers using its own stall.
   task automatic tick();
      logic s, rr, rt, b;
      logic [1:0] sr, st;
      wr_t w;
      model_all(s, sr, st, rr, rt, b);
      @(posedge clk);
      cyc++;
      if (!reset) begin
         if (!s && ifWrGrf_Id && grfWa_Id != 5'd0) begin
            w.enter = cyc;
            w.wa    = int'(grfWa_Id);
            w.tnew  = int'(tNew_Id);
            pipe_q.push_back(w);
         end
         if (!s && mdStart_Id) md_end = cyc + (isDiv_Id ? 10 : 5) - 1;
         if (s) stall_cnt++;
      end
      while (pipe_q.size() > 0 && (cyc - pipe_q[0].enter) > 2) void'(pipe_q.pop_front());
      @(negedge clk);
   endtask

   task automatic drive(input logic rd1, input logic [4:0] ra1, input logic [4:0] tu1,
                        input logic rd2, input logic [4:0] ra2, input logic [4:0] tu2,
                        input logic wr, input logic [4:0] wa, input logic [4:0] tn,
                        input logic mduse, input logic mdstart, input logic isdiv);
      ifReGrf1_Id = rd1; grfRa1_Id = ra1; tUseRs_Id = tu1;
      ifReGrf2_Id = rd2; grfRa2_Id = ra2; tUseRt_Id = tu2;
      ifWrGrf_Id  = wr;  grfWa_Id  = wa;  tNew_Id   = tn;
      mdUse_Id    = mduse; mdStart_Id = mdstart; isDiv_Id = isdiv;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic step();
      #1;
      check_all();
      tick();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #2;
      chk("rst_stall", 32'(stall),    32'd0);
      chk("rst_selrs", 32'(fwdSelRs), 32'd0);
      chk("rst_rdyrs", 32'(fwdRdyRs), 32'd0);
      chk("rst_busy",  32'(mdBusy),   32'd0);
      chk("rst_cnt",   stallCount,    32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Load-use: lw $8 (tNew 2) followed by addu reading $8 (tUse 1).
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 5'd2, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd8, 5'd1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd10, 5'd1, 1'b0, 1'b0, 1'b0);
      #1;
      check_all();
      chk("lu_stall1", 32'(stall), 32'd1);
      tick();
      #1;
      check_all();
      chk("lu_stall2", 32'(stall),    32'd0);
      chk("lu_sel",    32'(fwdSelRs), 32'd2);
      // the lw copy in M still has one cycle to go
      chk("lu_rdy",    32'(fwdRdyRs), 32'd0);
      tick();
      idle();
      repeat (3) step();

      // ALU back-to-back with tUse 0: one stall, then forward from M.
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 5'd1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("alu_stall1", 32'(stall), 32'd1);
      tick();
      #1;
      chk("alu_stall2", 32'(stall),    32'd0);
      chk("alu_sel",    32'(fwdSelRs), 32'd2);
      chk("alu_rdy",    32'(fwdRdyRs), 32'd1);
      tick();
      idle();
      repeat (3) step();

      // Same with tUse 1: no stall, forward from E not yet ready.
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 5'd1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd9, 5'd1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check_all();
      chk("alu1_stall", 32'(stall),    32'd0);
      chk("alu1_sel",   32'(fwdSelRs), 32'd1);
      chk("alu1_rdy",   32'(fwdRdyRs), 32'd0);
      tick();
      idle();
      repeat (3) step();

      // $0 is never tracked.
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("z_stall", 32'(stall),    32'd0);
      chk("z_selrs", 32'(fwdSelRs), 32'd0);
      chk("z_selrt", 32'(fwdSelRt), 32'd0);
      tick();

      // $5 in both M and E: the younger E copy wins.
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      drive(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check_all();
      chk("pri_selrs", 32'(fwdSelRs), 32'd1);
      chk("pri_selrt", 32'(fwdSelRt), 32'd1);
      tick();
      idle();
      repeat (3) step();

      // div followed by mflo: ten busy/stall cycles.
      do_reset();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      #1;
      chk("div_issue_stall", 32'(stall), 32'd0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         #1;
         check_all();
         chk("div_stall", 32'(stall),  32'd1);
         chk("div_busy",  32'(mdBusy), 32'd1);
         tick();
      end
      #1;
      chk("div_free",  32'(stall),  32'd0);
      chk("div_idle",  32'(mdBusy), 32'd0);
      tick();
      idle();
      #1;
      chk("div_count", stallCount, 32'd10);
      tick();

      // Reset asserted in the middle of a load-use stall with mult busy.
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 5'd2, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd8, 5'd1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd10, 5'd1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("ar_pre_stall", 32'(stall),  32'd1);
      chk("ar_pre_busy",  32'(mdBusy), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      model_reset();
      chk("ar_stall", 32'(stall),    32'd0);
      chk("ar_selrs", 32'(fwdSelRs), 32'd0);
      chk("ar_rdyrs", 32'(fwdRdyRs), 32'd0);
      chk("ar_busy",  32'(mdBusy),   32'd0);
      chk("ar_cnt",   stallCount,    32'd0);
      idle();
      tick();
      reset = 1'b0;

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 11) == 0),
               1'($urandom_range(0, 1)));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
